// File: rtl/arb_rrb_oht.sv
// Round-robin arbiter with a registered one-hot grant.
// The grant is held until the downstream stage accepts it.
module arb_rrb_oht #(
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld,
  input  logic             rdy
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [WIDTH-1:0] gnt_nxt;
  logic             trn;
  logic             arb_en;
  logic             hit;

  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % WIDTH);
  endfunction

  assign vld    = |gnt;
  assign trn    = vld & rdy;
  assign arb_en = ~vld | trn;

  // The search base already reflects a transfer completing this cycle.
  assign ptr_nxt = trn ? idx : ptr;

  always_comb begin
    hit     = 1'b0;
    idx_nxt = '0;
    gnt_nxt = '0;
    for (int j = 1; j <= WIDTH; j++) begin
      if (!hit && req[wrap(int'(ptr_nxt) + j)]) begin
        hit     = 1'b1;
        idx_nxt = wrap(int'(ptr_nxt) + j);
      end
    end
    if (hit) begin
      gnt_nxt = WIDTH'(1) << idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
      idx <= '0;
      ptr <= IDX_W'(WIDTH - 1);
    end else begin
      if (trn) begin
        ptr <= idx;
      end
      if (arb_en) begin
        gnt <= gnt_nxt;
        idx <= idx_nxt;
      end
    end
  end

endmodule

// File: tb/tb_arb_rrb_oht.sv
// Directed bench for arb_rrb_oht.
// Includes a bench-side one-hot mux model.
module tb_arb_rrb_oht;

  localparam int WIDTH = 16;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] gnt;
  logic [IDX_W-1:0] idx;
  logic             vld;
  logic             rdy;

  int n_cmp;
  int n_err;

  arb_rrb_oht #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .idx  (idx),
    .vld  (vld),
    .rdy  (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Bench model of the downstream one-hot mux with ary[i] = i.
  function automatic logic [IDX_W-1:0] mux_dat(input logic [WIDTH-1:0] g);
    logic [IDX_W-1:0] d;
    d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (g[i]) d = d | IDX_W'(i);
    end
    return d;
  endfunction

  // Invariants sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("inv_vld", 32'(vld), 32'(|gnt));
      if (vld) chk("inv_gnt_idx", 32'(gnt), 32'(WIDTH'(1) << idx));
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 16'hFFFF;
    rdy   = 1'b0;

    // Reset with all requests asserted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_idx", 32'(idx), 32'h0);

    rst_n = 1'b1;
    req   = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_vld", 32'(vld), 32'h0);
    end

    // Single requester, re-granted while it stays the only one.
    req = 16'h0020;
    step();
    chk("single_gnt", 32'(gnt), 32'h0020);
    chk("single_idx", 32'(idx), 32'd5);
    chk("single_vld", 32'(vld), 32'h1);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_regnt", 32'(gnt), 32'h0020);
    end
    req = '0;
    step();
    chk("single_done_vld", 32'(vld), 32'h0);

    // Full rotation with wrap, checked through the mux model.
    rst_pulse();
    chk("rot_rst_gnt", 32'(gnt), 32'h0);
    req = 16'hFFFF;
    rdy = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      chk("rot_idx", 32'(idx), 32'(i % WIDTH));
      chk("rot_gnt", 32'(gnt), 32'(16'h1 << (i % WIDTH)));
      chk("mux_dat", 32'(mux_dat(gnt)), 32'(i % WIDTH));
      chk("mux_vld", 32'(|gnt), 32'h1);
    end
    rdy = 1'b0;
    req = '0;

    // Lock under backpressure; grant survives request drop.
    rst_pulse();
    req = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_gnt", 32'(gnt), 32'h0001);
      if (i == 1) req = 16'h0002;
    end
    rdy = 1'b1;
    step();
    chk("lock_next_gnt", 32'(gnt), 32'h0002);
    chk("lock_next_idx", 32'(idx), 32'd1);
    rdy = 1'b0;
    req = '0;

    // Fairness: after serving 9, requester 0 wins before 9 again.
    rst_pulse();
    req = 16'h0200;
    step();
    chk("fair_first_idx", 32'(idx), 32'd9);
    req = 16'h0201;
    rdy = 1'b1;
    step();
    chk("fair_idx0", 32'(idx), 32'd0);
    step();
    chk("fair_idx9", 32'(idx), 32'd9);
    rdy = 1'b0;
    req = '0;

    // Asynchronous reset between edges.
    rst_pulse();
    req = 16'h0100;
    step();
    chk("ar_pre_gnt", 32'(gnt), 32'h0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'h0);
    chk("ar_vld", 32'(vld), 32'h0);
    rst_n = 1'b1;
    step();
    chk("ar_post_idx", 32'(idx), 32'd8);
    chk("ar_post_gnt", 32'(gnt), 32'h0100);

    req = '0;
    rdy = 1'b1;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
